mult_share_sched: RTL and testbench
===================================

// Module: mult_share_sched
// PURPOSE
//  Shares one combinational 4x4 unsigned array multiplier between N_REQ requesters.
//  Round-robin arbitration picks one request at a time.
//  Registered operands drive the multiplier; its product is sampled after MUL_LAT cycles.
//  The result is returned on a valid/ready response channel tagged with the requester id.
//  Sits between the requesting datapath blocks and the single multiplier instance.
// PARAMETERS
//  N_REQ    4  number of requesters (>=2)
//  W        4  operand width; product is 2*W bits
//  MUL_LAT  1  cycles from registered operands to product sampling (>=1; 0 illegal)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            synchronous reset, active-high
//  req_valid  in   N_REQ        request pending, one bit per requester
//  req_x      in   N_REQ*W      operand x; requester i at [i*W +: W]
//  req_y      in   N_REQ*W      operand y; requester i at [i*W +: W]
//  req_ready  out  N_REQ        grant/accept, one-hot or zero
//  mul_x      out  W            registered operand x to the shared multiplier
//  mul_y      out  W            registered operand y to the shared multiplier
//  mul_o      in   2*W          product returned by the shared multiplier
//  rsp_valid  out  1            response valid
//  rsp_ready  in   1            response accepted by consumer
//  rsp_prod   out  2*W          unsigned product x*y
//  rsp_id     out  clog2(N_REQ) index of the requester that owns rsp_prod
//  busy       out  1            high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst high at a clock edge):
//   - state=IDLE, rr_ptr=0, mul_x=0, mul_y=0, rsp_valid=0, rsp_prod=0, rsp_id=0.
//   - req_ready is forced to 0 while rst is high.
//   - Any in-flight operation is dropped; no response is ever produced for it.
//  FSM IDLE:
//   - grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - req_ready[g]=1 combinationally, in IDLE only; all other req_ready bits are 0.
//   - On accept in cycle T: mul_x<=req_x[g], mul_y<=req_y[g], id<=g, cnt<=MUL_LAT; go to WAIT.
//   - No req_valid set: remain in IDLE; req_ready stays 0.
//  FSM WAIT:
//   - cnt decrements by 1 each cycle.
//   - In the cycle where cnt==1: rsp_prod<=mul_o, rsp_id<=id, rsp_valid<=1; go to HOLD.
//  FSM HOLD:
//   - rsp_valid, rsp_prod and rsp_id hold stable until rsp_ready=1.
//   - On handshake: rsp_valid<=0, rr_ptr<=(id+1) mod N_REQ, go to IDLE.
//   - No new grant is issued in the same cycle as the handshake.
//  Latency and throughput:
//   - Accept at cycle T gives rsp_valid=1 from cycle T+1+MUL_LAT.
//   - At most 1 operation outstanding.
//   - Minimum request spacing is MUL_LAT+2 cycles when rsp_ready is held high.
//  Operand stability:
//   - mul_x/mul_y change only on accept or reset; they are stable through WAIT and HOLD.
//  Request side:
//   - req_x/req_y are sampled only on accept.
//   - Dropping req_valid before a grant is legal and has no effect.
//  Arithmetic: unsigned, no truncation; rsp_prod equals mul_o exactly (2*W bits).
//  rr_ptr wraps from N_REQ-1 to 0. busy = (state != IDLE).
// TESTING
//  1 Single request, N_REQ=4, MUL_LAT=1: req 2, x=13, y=11 accepted at T
//    -> rsp_valid at T+2, rsp_prod=143, rsp_id=2.
//  2 After reset, req_valid=4'b1111 held, rsp_ready=1
//    -> grants in order 0,1,2,3,0; exactly one req_ready bit high per grant.
//  3 rsp_ready=0 for 5 cycles in HOLD
//    -> rsp_prod/rsp_id/mul_x stable, req_ready=0, busy=1; completes on rsp_ready=1.
//  4 Wrap: last served id=3, then req_valid=4'b1001
//    -> grant 0 first, then 3.
//  5 rst pulsed in WAIT
//    -> next cycle state=IDLE, rsp_valid=0, busy=0; no stale response afterwards.
//  6 MUL_LAT=3: all 256 (x,y) pairs sent via req 1
//    -> each rsp_prod==x*y (15*15=225); rsp_valid at T+4.

Source files
------------

// File: rtl/mult_share_sched.sv
`default_nettype none
// =============================================================================
// Module      : mult_share_sched
// Description : Round-robin scheduler that time-shares one combinational
//               W x W unsigned multiplier among N_REQ requesters and returns
//               each product on a valid/ready channel tagged with the owner.
// Revision    : 1.0 - initial release
// =============================================================================
module mult_share_sched #(
   parameter int N_REQ   = 4,
   parameter int W       = 4,
   parameter int MUL_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*W-1:0]         req_x,
   input  logic [N_REQ*W-1:0]         req_y,
   output logic [N_REQ-1:0]           req_ready,
   output logic [W-1:0]               mul_x,
   output logic [W-1:0]               mul_y,
   input  logic [2*W-1:0]             mul_o,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [2*W-1:0]             rsp_prod,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic                       busy
);

   localparam int c_ID_W  = $clog2(N_REQ);
   localparam int c_CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_ID_W-1:0]   r_rr_ptr;
   logic [c_ID_W-1:0]   r_id;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [W-1:0]        r_mul_x;
   logic [W-1:0]        r_mul_y;
   logic                r_rsp_valid;
   logic [2*W-1:0]      r_rsp_prod;
   logic [c_ID_W-1:0]   r_rsp_id;

   logic                w_found;
   logic [c_ID_W-1:0]   w_grant_id;
   logic [N_REQ-1:0]    w_grant_oh;
   logic [W-1:0]        w_sel_x;
   logic [W-1:0]        w_sel_y;
   logic                w_accept;
   logic                w_done;
   logic                w_handshake;

   // Round-robin: lowest valid index at or above the pointer wins, otherwise
   // wrap around to the lowest valid index overall.
   always_comb begin : rr_search
      logic             v_found_hi;
      logic [c_ID_W-1:0] v_hi;
      logic [c_ID_W-1:0] v_lo;
      v_found_hi = 1'b0;
      v_hi       = '0;
      v_lo       = '0;
      w_found    = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            w_found = 1'b1;
            v_lo    = c_ID_W'(i);
            if (i >= int'(r_rr_ptr)) begin
               v_found_hi = 1'b1;
               v_hi       = c_ID_W'(i);
            end
         end
      end
      w_grant_id = v_found_hi ? v_hi : v_lo;
   end

   always_comb begin : operand_mux
      w_sel_x    = '0;
      w_sel_y    = '0;
      w_grant_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (c_ID_W'(i) == w_grant_id) begin
            w_sel_x       = req_x[i*W +: W];
            w_sel_y       = req_y[i*W +: W];
            w_grant_oh[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin : fsm_next
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_handshake = 1'b0;
      req_ready   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_found && !rst) begin
               w_accept    = 1'b1;
               req_ready   = w_grant_oh;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == c_CNT_W'(1)) begin
               w_done      = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (rsp_ready) begin
               w_handshake = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_id        <= '0;
         r_cnt       <= '0;
         r_mul_x     <= '0;
         r_mul_y     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_prod  <= '0;
         r_rsp_id    <= '0;
      end else begin
         if (w_accept) begin
            r_mul_x <= w_sel_x;
            r_mul_y <= w_sel_y;
            r_id    <= w_grant_id;
            r_cnt   <= c_CNT_W'(MUL_LAT);
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
         end
         if (w_done) begin
            r_rsp_prod  <= mul_o;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
         end
         if (w_handshake) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= (r_id == c_ID_W'(N_REQ - 1)) ? '0 : r_id + c_ID_W'(1);
         end
      end
   end

   assign mul_x     = r_mul_x;
   assign mul_y     = r_mul_y;
   assign rsp_valid = r_rsp_valid;
   assign rsp_prod  = r_rsp_prod;
   assign rsp_id    = r_rsp_id;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`default_nettype none
// =============================================================================
// Module      : tb_mult_share_sched
// Description : Randomized self-checking bench for mult_share_sched with a
//               transaction-level round-robin/product reference model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mult_share_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   bit          sel = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_x = '0;
   logic [15:0] req_y = '0;
   logic        rsp_ready = 1'b0;

   logic [3:0] w_v1, w_v3, rr1, rr3;
   logic [3:0] mx1, my1, mx3, my3;
   logic [7:0] mo1, mo3, pr1, pr3;
   logic [1:0] id1, id3;
   logic       rv1, rv3, b1, b3, w_rr1, w_rr3;

   logic [3:0] o_rdy, o_mx, o_my;
   logic [7:0] o_prod;
   logic [1:0] o_id;
   logic       o_rv, o_busy;

   int n_cmp = 0;
   int n_bad = 0;
   int m_ptr [2];

   always #5 clk = ~clk;

   // The bench plays the role of the shared combinational multiplier.
   assign mo1   = {4'b0, mx1} * {4'b0, my1};
   assign mo3   = {4'b0, mx3} * {4'b0, my3};
   assign w_v1  = sel ? 4'b0 : req_valid;
   assign w_v3  = sel ? req_valid : 4'b0;
   assign w_rr1 = sel ? 1'b0 : rsp_ready;
   assign w_rr3 = sel ? rsp_ready : 1'b0;

   assign o_rdy  = sel ? rr3 : rr1;
   assign o_mx   = sel ? mx3 : mx1;
   assign o_my   = sel ? my3 : my1;
   assign o_prod = sel ? pr3 : pr1;
   assign o_id   = sel ? id3 : id1;
   assign o_rv   = sel ? rv3 : rv1;
   assign o_busy = sel ? b3  : b1;

   mult_share_sched #(.N_REQ(4), .W(4), .MUL_LAT(1)) dut (
      .clk(clk), .rst(rst), .req_valid(w_v1), .req_x(req_x), .req_y(req_y),
      .req_ready(rr1), .mul_x(mx1), .mul_y(my1), .mul_o(mo1),
      .rsp_valid(rv1), .rsp_ready(w_rr1), .rsp_prod(pr1), .rsp_id(id1), .busy(b1));

   mult_share_sched #(.N_REQ(4), .W(4), .MUL_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(w_v3), .req_x(req_x), .req_y(req_y),
      .req_ready(rr3), .mul_x(mx3), .mul_y(my3), .mul_o(mo3),
      .rsp_valid(rv3), .rsp_ready(w_rr3), .rsp_prod(pr3), .rsp_id(id3), .busy(b3));

   // One complete transaction, entered and left at a falling edge in IDLE.
   task automatic txn(input logic [3:0] mask, input logic [15:0] xs, input logic [15:0] ys,
                      input int hold, input bit keep);
      int         g, lat;
      logic [1:0] ix;
      logic [3:0] ex, ey, erdy;
      logic [7:0] ep;
      lat = sel ? 3 : 1;
      g   = -1;
      for (int k = 0; k < 4; k++) begin
         ix = 2'((m_ptr[sel] + k) % 4);
         if (g < 0 && mask[ix]) g = int'(ix);
      end
      ex   = 4'(xs >> (4 * g));
      ey   = 4'(ys >> (4 * g));
      erdy = 4'(1 << g);
      ep   = 8'(int'(ex) * int'(ey));
      req_valid = mask; req_x = xs; req_y = ys; rsp_ready = 1'b0;
      #1;
      n_cmp++;
      if (o_rdy !== erdy || o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL grant: req_ready=%b busy=%b required req_ready=%b busy=0", o_rdy, o_busy, erdy);
      end
      @(posedge clk);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (!keep) req_valid = '0;
         n_cmp++;
         if (o_rv !== 1'b0 || o_busy !== 1'b1 || o_rdy !== 4'b0 || o_mx !== ex || o_my !== ey) begin
            n_bad++;
            $display("FAIL wait: rv=%b busy=%b rdy=%b x=%0d y=%0d required rv=0 busy=1 rdy=0 x=%0d y=%0d",
                     o_rv, o_busy, o_rdy, o_mx, o_my, ex, ey);
         end
      end
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         n_cmp++;
         if (o_rv !== 1'b1 || o_prod !== ep || o_id !== 2'(g) || o_busy !== 1'b1 ||
             o_rdy !== 4'b0 || o_mx !== ex || o_my !== ey) begin
            n_bad++;
            $display("FAIL response: rv=%b prod=%0d id=%0d busy=%b rdy=%b x=%0d required rv=1 prod=%0d id=%0d busy=1 rdy=0 x=%0d",
                     o_rv, o_prod, o_id, o_busy, o_rdy, o_mx, ep, g, ex);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++;
      if (o_rv !== 1'b0 || o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL complete: rv=%b busy=%b required rv=0 busy=0", o_rv, o_busy);
      end
      m_ptr[sel] = (g + 1) % 4;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_ptr[0] = 0; m_ptr[1] = 0;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111; req_x = 16'hFFFF; req_y = 16'hFFFF;
      @(negedge clk); @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         #1;
         n_cmp++;
         if (o_rdy !== 4'b0 || o_busy !== 1'b0 || o_rv !== 1'b0 || o_prod !== 8'd0 ||
             o_id !== 2'd0 || o_mx !== 4'd0 || o_my !== 4'd0) begin
            n_bad++;
            $display("FAIL reset[%0d]: rdy=%b busy=%b rv=%b prod=%0d id=%0d x=%0d y=%0d required all zero",
                     s, o_rdy, o_busy, o_rv, o_prod, o_id, o_mx, o_my);
         end
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0; req_valid = '0;
      m_ptr[0] = 0; m_ptr[1] = 0;
   endtask

   task automatic test_single();
      txn(4'b0100, 16'h0D00, 16'h0B00, 0, 1'b0);
   endtask

   task automatic test_rr_order();
      do_reset();
      for (int k = 0; k < 5; k++) txn(4'b1111, 16'($urandom), 16'($urandom), 0, 1'b1);
   endtask

   task automatic test_hold();
      txn(4'b1111, 16'($urandom), 16'($urandom), 5, 1'b1);
   endtask

   task automatic test_wrap();
      txn(4'b1000, 16'($urandom), 16'($urandom), 0, 1'b0);
      txn(4'b1001, 16'($urandom), 16'($urandom), 0, 1'b1);
      txn(4'b1001, 16'($urandom), 16'($urandom), 1, 1'b1);
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      req_valid = 4'b0001; req_x = 16'h0007; req_y = 16'h0009;
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b1111;
      n_cmp++;
      if (o_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_busy: busy=%b required 1", o_busy);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (o_busy !== 1'b0 || o_rv !== 1'b0 || o_rdy !== 4'b0 || o_mx !== 4'd0) begin
         n_bad++;
         $display("FAIL reset_in_wait: busy=%b rv=%b rdy=%b x=%0d required 0 0 0000 0",
                  o_busy, o_rv, o_rdy, o_mx);
      end
      rst = 1'b0; req_valid = '0;
      m_ptr[0] = 0; m_ptr[1] = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (o_rv !== 1'b0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_response: rv=%b busy=%b required 0 0", o_rv, o_busy);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] m;
      for (int n = 0; n < 40; n++) begin
         m = 4'($urandom_range(1, 15));
         txn(m, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end
   endtask

   task automatic test_exhaustive_lat3();
      logic [15:0] xs, ys;
      sel = 1'b1;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            xs = 16'($urandom); ys = 16'($urandom);
            xs[7:4] = 4'(x); ys[7:4] = 4'(y);
            txn(4'b0010, xs, ys, int'($urandom_range(0, 1)), 1'($urandom));
         end
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_order();
      test_hold();
      test_wrap();
      test_reset_in_wait();
      test_random();
      test_exhaustive_lat3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
